// File: rtl/cnn_pkg.sv
// Shared CNN definitions: fixed-point word format, scheduler state encoding
// and the filter weight-width helper.
package cnn_pkg;

  localparam int unsigned N = 24;
  localparam int unsigned Q = 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } sched_state_t;

  // Flattened 3x3xC filter word width
  function automatic int unsigned weight_w(input int unsigned n, input int unsigned c);
    return 9 * n * c;
  endfunction

endpackage

// File: rtl/conv_channel_sched_wait_cnt.sv
// sched_wait_cnt: loadable down-counter with a terminal-count flag, used to
// time the Conv2d settle latency.
module sched_wait_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_tc_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/conv_channel_sched.sv
// Per-layer output-channel sequencer for Conv2d: ROM fetch, weight hold,
// settle wait, result handoff. Optional CONV_SCHED_PERF_EN adds a stall counter.
module conv_channel_sched
  import cnn_pkg::*;
#(
  parameter int unsigned N        = cnn_pkg::N,
  parameter int unsigned C        = 1,
  parameter int unsigned OUTCH    = 64,
  parameter int unsigned CONV_LAT = 4,
  parameter int unsigned RES_W    = 24 * 32 * 160,
  parameter int unsigned AW       = 6
) (
  input  logic                    clk,
  input  logic                    global_rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rom_en,
  output logic [AW-1:0]           rom_addr,
  input  logic [weight_w(N,C)-1:0] rom_weight,
  input  logic [N-1:0]            rom_bias,
  output logic [weight_w(N,C)-1:0] conv_weight,
  output logic [N-1:0]            conv_bias,
  input  logic [RES_W-1:0]        conv_result,
  output logic [RES_W-1:0]        res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [AW-1:0]           ch_idx
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]             busy_cycles
`endif
);

  localparam int unsigned WW = weight_w(N, C);
  localparam int unsigned CW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam logic [AW-1:0] LAST_CH = AW'(OUTCH - 1);

  sched_state_t     r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_rom_en;
  logic [AW-1:0]    r_rom_addr;
  logic [AW-1:0]    r_ch_idx;
  logic [WW-1:0]    r_conv_weight;
  logic [N-1:0]     r_conv_bias;
  logic [RES_W-1:0] r_res_data;
  logic             r_res_valid;

  logic             w_wait_load;
  logic             w_wait_dec;
  logic             w_wait_tc;
  logic             w_xfer;
  logic             w_start_acc;

  assign w_wait_load = (r_state == S_LOAD);
  assign w_wait_dec  = (r_state == S_WAIT);
  assign w_xfer      = r_res_valid && res_ready;
  assign w_start_acc = (r_state == S_IDLE) && start;

  // Counts CONV_LAT WAIT cycles: loaded in LOAD, terminal on the last one
  sched_wait_cnt #(
    .W (CW)
  ) u_wait_cnt (
    .clk        (clk),
    .i_rst      (global_rst),
    .i_load     (w_wait_load),
    .i_load_val (CW'(CONV_LAT - 1)),
    .i_dec      (w_wait_dec),
    .o_tc_c     (w_wait_tc)
  );

  // Sequencer: all outputs are registered alongside the state transition
  always_ff @(posedge clk) begin
    if (global_rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rom_en      <= 1'b0;
      r_rom_addr    <= '0;
      r_ch_idx      <= '0;
      r_conv_weight <= '0;
      r_conv_bias   <= '0;
      r_res_data    <= '0;
      r_res_valid   <= 1'b0;
    end else begin
      r_rom_en <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            r_ch_idx   <= '0;
            r_rom_addr <= '0;
            r_rom_en   <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          // ROM data is valid the cycle after the read strobe
          r_conv_weight <= rom_weight;
          r_conv_bias   <= rom_bias;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          if (w_wait_tc) begin
            r_res_data  <= conv_result;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_xfer) begin
            r_res_valid <= 1'b0;
            if (r_ch_idx == LAST_CH) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_ch_idx   <= r_ch_idx + AW'(1);
              r_rom_addr <= r_ch_idx + AW'(1);
              r_rom_en   <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rom_en      = r_rom_en;
  assign rom_addr    = r_rom_addr;
  assign ch_idx      = r_ch_idx;
  assign conv_weight = r_conv_weight;
  assign conv_bias   = r_conv_bias;
  assign res_data    = r_res_data;
  assign res_valid   = r_res_valid;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] r_busy_cycles;

  // Saturating count of backpressure stall cycles within one layer
  always_ff @(posedge clk) begin
    if (global_rst || w_start_acc) begin
      r_busy_cycles <= '0;
    end else if (r_busy && r_res_valid && !res_ready && (r_busy_cycles != '1)) begin
      r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

  assign busy_cycles = r_busy_cycles;
`else
  logic w_unused;
  assign w_unused = w_start_acc;
`endif

endmodule

// File: tb/tb_conv_channel_sched.sv
// Scoreboard bench for conv_channel_sched with a small ROM and Conv2d model;
// checks busy_cycles when CONV_SCHED_PERF_EN is defined.
module tb_conv_channel_sched;
  import cnn_pkg::*;

  localparam int unsigned C        = 1;
  localparam int unsigned OUTCH    = 4;
  localparam int unsigned CONV_LAT = 2;
  localparam int unsigned RES_W    = 48;
  localparam int unsigned AW       = 6;
  localparam int unsigned WW       = 9 * N * C;

  logic             clk;
  logic             global_rst;
  logic             start;
  logic             busy, done, rom_en, res_valid;
  logic             res_ready = 1'b1;
  logic [AW-1:0]    rom_addr, ch_idx;
  logic [WW-1:0]    rom_weight, conv_weight;
  logic [N-1:0]     rom_bias, conv_bias;
  logic [RES_W-1:0] conv_result, res_data, conv_pipe;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]      busy_cycles;
`endif

  conv_channel_sched #(
    .N(N), .C(C), .OUTCH(OUTCH), .CONV_LAT(CONV_LAT), .RES_W(RES_W), .AW(AW)
  ) dut (
`ifdef CONV_SCHED_PERF_EN
    .busy_cycles (busy_cycles),
`endif
    .clk         (clk),
    .global_rst  (global_rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_weight  (rom_weight),
    .rom_bias    (rom_bias),
    .conv_weight (conv_weight),
    .conv_bias   (conv_bias),
    .conv_result (conv_result),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .ch_idx      (ch_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word k = k+1, one cycle read latency
  always @(posedge clk) begin
    if (rom_en) begin
      rom_weight <= WW'(rom_addr) + WW'(1);
      rom_bias   <= N'(rom_addr) + N'(1);
    end
  end

  // Conv2d stand-in: result follows weights CONV_LAT-1 = 1 register later
  always @(posedge clk) conv_pipe <= {conv_weight[23:0] ^ 24'hA5A5A5, conv_bias};
  assign conv_result = conv_pipe;

  // Hand-computed result maps for channels 0..3
  logic [RES_W-1:0] exp_res [4] = '{48'hA5A5A4_000001, 48'hA5A5A7_000002,
                                    48'hA5A5A6_000003, 48'hA5A5A1_000004};

  typedef struct {
    logic [AW-1:0]    ch;
    logic [RES_W-1:0] data;
    logic [N-1:0]     bias;
    int               gap;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ready driver: stalls channel 1 for stall_req cycles, or indefinitely when hold_ch1
  int stall_req = 0;
  bit hold_ch1  = 1'b0;
  int stalls_done = 0;
  always @(posedge clk) begin
    #1;
    if (res_valid && ch_idx == AW'(1) && (hold_ch1 || stalls_done < stall_req)) begin
      res_ready = 1'b0;
      stalls_done++;
    end else begin
      res_ready = 1'b1;
    end
    if (!busy) stalls_done = 0;
  end

  // Monitor: scoreboard pops, stall stability, ROM strobe and weight timing
  int               done_cnt = 0;
  int               rom_exp = 0;
  int               last_xfer = -1;
  bit               prev_stall = 1'b0;
  logic [RES_W-1:0] prev_data;
  bit               rom_d1 = 1'b0, rom_d2 = 1'b0;
  logic [AW-1:0]    d1_addr, d2_addr;
  exp_t             e;

  always @(negedge clk) begin
    if (global_rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
      rom_d1 = 1'b0;
      rom_d2 = 1'b0;
      last_xfer = -1;
    end else begin
      if (!busy && start) rom_exp = 0;
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected: got ch %0d want none", ch_idx);
        end else begin
          e = sb_q.pop_front();
          check("xfer_data", 64'(res_data), 64'(e.data));
          check("xfer_ch", 64'(ch_idx), 64'(e.ch));
          check("xfer_bias", 64'(conv_bias), 64'(e.bias));
          if (e.gap > 0) check("xfer_gap", 64'(cyc - last_xfer), 64'(e.gap));
        end
        last_xfer = cyc;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(res_valid), 64'd1);
        check("stall_data", 64'(res_data), 64'(prev_data));
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      if (rom_en) begin
        check("rom_addr", 64'(rom_addr), 64'(rom_exp));
        rom_exp++;
      end
      if (rom_d1) check("w_not_early", 64'(conv_weight == WW'(d1_addr) + WW'(1)), 64'd0);
      if (rom_d2) check("w_loaded", conv_weight[63:0], 64'(d2_addr) + 64'd1);
      rom_d2 = rom_d1;  d2_addr = d1_addr;
      rom_d1 = rom_en;  d1_addr = rom_addr;
      if (done) done_cnt++;
    end
  end

  task automatic push_layer(input int stall_n);
    for (int k = 0; k < 4; k++) begin
      e.ch   = AW'(k);
      e.data = exp_res[k];
      e.bias = N'(k + 1);
      e.gap  = (k == 0) ? 0 : ((k == 1) ? 5 + stall_n : 5);
      sb_q.push_back(e);
    end
  endtask

  task automatic run_layer(input int stall_n, input int exp_done, input bit spurious);
    int n;
    int d0;
    bit sp_done;
    sp_done   = 1'b0;
    stall_req = stall_n;
    d0        = done_cnt;
    push_layer(stall_n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (spurious && !sp_done && ch_idx == AW'(2) && conv_bias == N'(3) && !res_valid) begin
        start   = 1'b1;
        sp_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    check("done_cycle", 64'(n), 64'(exp_done));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("rom_reads", 64'(rom_exp), 64'd4);
`ifdef CONV_SCHED_PERF_EN
    check("busy_cycles", 64'(busy_cycles), 64'(stall_n));
`endif
    stall_req = 0;
  endtask

  initial begin
    int n;
    int d0;
    global_rst = 1'b1;
    start      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rom_en", 64'(rom_en), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_ch_idx", 64'(ch_idx), 64'd0);
    check("rst_weight", conv_weight[63:0], 64'd0);
    check("rst_bias", 64'(conv_bias), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    global_rst = 1'b0;
    @(posedge clk);
    #1;

    run_layer(0, 21, 1'b0);  // continuous accept
    run_layer(7, 28, 1'b0);  // 7-cycle backpressure on channel 1
    run_layer(0, 21, 1'b1);  // spurious start during WAIT of channel 2

    // Reset while channel 1 sits in OUT
    hold_ch1 = 1'b1;
    d0 = done_cnt;
    push_layer(0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (res_valid && ch_idx == AW'(1)) break;
    end
    check("reached_ch1_out", 64'(res_valid && ch_idx == AW'(1)), 64'd1);
    global_rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(res_valid), 64'd0);
    check("midrst_ch_idx", 64'(ch_idx), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_res_data", 64'(res_data), 64'd0);
    check("midrst_weight", conv_weight[63:0], 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 global_rst = 1'b0;
    hold_ch1 = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk);
    #1;
    run_layer(0, 21, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
